// File: rtl/arb_grant_servicer.sv
// Services one arbiter grant at a time: latches the granted channel, streams its beats
// onto a valid/ready channel, pops the source per beat and acks the arbiter once.
// Optional stall timeout enabled by defining ARB_SVC_TIMEOUT_EN.
module arb_grant_servicer #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned CHAN_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [WIDTH-1:0]        grant,
  output logic                    ack,
  input  logic [WIDTH*DATA_W-1:0] req_data,
  input  logic [WIDTH*LEN_W-1:0]  req_len,
  output logic [WIDTH-1:0]        src_pop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [CHAN_W-1:0]       out_chan,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_grant,
  output logic                    err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CHAN_W-1:0] chan_q;
  logic [CHAN_W-1:0] grant_idx;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  grant_len;
  logic [DATA_W-1:0] sel_data;
  logic              err_grant_q;
  logic              grant_multi;
  logic              grant_onehot;
  logic              last_beat;
  logic              beat_acc;
  logic              timeout_hit;

  // One-hot grant to channel index and that channel's beat count
  always_comb begin
    grant_idx = '0;
    grant_len = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (grant[i]) begin
        grant_idx = CHAN_W'(i);
        grant_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign grant_multi  = (grant & (grant - WIDTH'(1))) != '0;
  assign grant_onehot = (grant != '0) && !grant_multi;

  // Head-of-queue data of the latched channel
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (chan_q == CHAN_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign last_beat = (cnt_q == (len_q - LEN_W'(1)));
  assign out_chan  = chan_q;
  assign err_grant = err_grant_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ack       = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    src_pop   = '0;
    beat_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_onehot) state_d = (grant_len == '0) ? DONE : XFER;
      end
      XFER: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sel_data;
        out_last  = last_beat;
        if (out_ready) begin
          beat_acc        = 1'b1;
          src_pop[chan_q] = 1'b1;
          if (last_beat) state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        ack     = 1'b1;
        state_d = GAP;
      end
      GAP: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Service context: latched channel, length and beat counter
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      chan_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_grant_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (grant_onehot) begin
        chan_q <= grant_idx;
        len_q  <= grant_len;
        cnt_q  <= '0;
      end
      if (grant_multi) err_grant_q <= 1'b1;
    end else if (beat_acc) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

`ifdef ARB_SVC_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q;
  logic               err_timeout_q;

  // Hit on the stall cycle that would bring the count to the limit
  assign timeout_hit = (state_q == XFER) && !out_ready &&
                       (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_timeout_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      stall_q       <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state_q == XFER && !out_ready) stall_q <= stall_q + STALL_W'(1);
      else                               stall_q <= '0;
      if (timeout_hit) err_timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^(32'(TIMEOUT_CYCLES));
  assign timeout_hit    = 1'b0;
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_arb_grant_servicer.sv
// Directed plus randomized checks of arb_grant_servicer against a per-requester
// source-queue model; the timeout scenario runs when ARB_SVC_TIMEOUT_EN is defined.
module tb_arb_grant_servicer;

  localparam int unsigned WIDTH          = 4;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned LEN_W          = 4;
  localparam int unsigned CHAN_W         = 2;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int          QDEPTH         = 64;

  logic                    clk = 1'b0;
  logic                    resetb;
  logic [WIDTH-1:0]        grant;
  logic                    ack;
  logic [WIDTH*DATA_W-1:0] req_data;
  logic [WIDTH*LEN_W-1:0]  req_len;
  logic [WIDTH-1:0]        src_pop;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [CHAN_W-1:0]       out_chan;
  logic                    out_last;
  logic                    busy;
  logic                    err_grant;
  logic                    err_timeout;

  arb_grant_servicer #(
    .WIDTH(WIDTH), .DATA_W(DATA_W), .LEN_W(LEN_W), .CHAN_W(CHAN_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .resetb(resetb), .grant(grant), .ack(ack),
    .req_data(req_data), .req_len(req_len), .src_pop(src_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .busy(busy),
    .err_grant(err_grant), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit exp_err_grant = 1'b0;
  logic [DATA_W-1:0] qmem [WIDTH][QDEPTH];
  int head [WIDTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < WIDTH; i++)
      req_data[i*DATA_W +: DATA_W] = qmem[i][head[i] % QDEPTH];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 always ready, 1 random ready, 2 ready low for the first 3 cycles
  task automatic service(input int ch, input int len, input int mode, input bit hold);
    logic [WIDTH-1:0]  g;
    logic [DATA_W-1:0] exp_d;
    int  beats = 0;
    int  k     = 0;
    bit  done  = 1'b0;
    bit  popped;
    g = WIDTH'(1) << ch;
    for (int i = 0; i < WIDTH; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom);
    req_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
    grant     = g;
    out_ready = 1'b0;
    tick();
    if (!hold) grant = WIDTH'($urandom);
    chk("chan", 32'(out_chan), 32'(ch));
    while (!done && k < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= 3);
      endcase
      #1;
      popped = 1'b0;
      if (beats == len) begin
        chk("done_ack", 32'(ack), 32'(1));
        chk("done_valid", 32'(out_valid), 32'(0));
        chk("done_pop", 32'(src_pop), 32'(0));
        done = 1'b1;
      end else begin
        exp_d = qmem[ch][head[ch] % QDEPTH];
        chk("valid", 32'(out_valid), 32'(1));
        chk("early_ack", 32'(ack), 32'(0));
        chk("data", 32'(out_data), 32'(exp_d));
        chk("last", 32'(out_last), 32'(beats == len - 1));
        chk("pop", 32'(src_pop), 32'(out_ready ? g : '0));
        if (out_ready) begin
          beats++;
          popped = 1'b1;
        end
      end
      tick();
      if (popped) begin
        head[ch]++;
        drive_heads();
      end
      k++;
    end
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL ack_wait: no ack within %0d cycles, beats %0d of %0d", k, beats, len);
    end
    if (!hold) grant = '0;
    #1;
    chk("gap_ack", 32'(ack), 32'(0));
    chk("gap_busy", 32'(busy), 32'(1));
    chk("gap_valid", 32'(out_valid), 32'(0));
    tick();
    grant = '0;
    #1;
    chk("idle_busy", 32'(busy), 32'(0));
    chk("err_grant", 32'(err_grant), 32'(exp_err_grant));
`ifndef ARB_SVC_TIMEOUT_EN
    chk("err_timeout", 32'(err_timeout), 32'(0));
`endif
    if (hold) begin
      tick();
      #1;
      chk("stale_busy", 32'(busy), 32'(0));
      chk("stale_ack", 32'(ack), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < WIDTH; i++) begin
      head[i] = 0;
      for (int j = 0; j < QDEPTH; j++) qmem[i][j] = DATA_W'($urandom);
    end
    resetb    = 1'b0;
    grant     = '0;
    out_ready = 1'b0;
    req_len   = '0;
    drive_heads();
    #2;
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_chan", 32'(out_chan), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_err", 32'({err_grant, err_timeout}), 32'(0));
    #20;
    resetb = 1'b1;
    tick();

    service(1, 3, 0, 1'b0);   // single requester, back-to-back beats
    service(3, 2, 2, 1'b0);   // backpressure on the first beat
    service(0, 0, 0, 1'b1);   // zero length with stale grant held
    service(2, 1, 0, 1'b0);   // minimum one-beat service

    grant = 4'b0110;
    tick();
    grant = '0;
    exp_err_grant = 1'b1;
    #1;
    chk("multi_err", 32'(err_grant), 32'(1));
    chk("multi_busy", 32'(busy), 32'(0));
    chk("multi_ack", 32'(ack), 32'(0));
    service(2, 2, 0, 1'b0);

    service(0, 15, 1, 1'b0);  // maximum length
    for (int n = 0; n < 20; n++)
      service(int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    // Reset mid-transfer after one accepted beat
    req_len[2*LEN_W +: LEN_W] = LEN_W'(3);
    grant     = 4'b0100;
    out_ready = 1'b1;
    tick();
    grant = '0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'(1));
    chk("mid_pop", 32'(src_pop), 32'(4'b0100));
    tick();
    head[2]++;
    drive_heads();
    resetb = 1'b0;
    exp_err_grant = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({ack, src_pop, out_valid, out_last, busy}), 32'(0));
    chk("mid_rst_chan", 32'(out_chan), 32'(0));
    chk("mid_rst_data", 32'(out_data), 32'(0));
    chk("mid_rst_err", 32'(err_grant), 32'(0));
    tick();
    resetb = 1'b1;
    tick();
    #1;
    chk("post_rst_busy", 32'(busy), 32'(0));
    chk("post_rst_ack", 32'({ack, out_valid}), 32'(0));
    service(2, 2, 1, 1'b0);

`ifdef ARB_SVC_TIMEOUT_EN
    req_len[1*LEN_W +: LEN_W] = LEN_W'(4);
    grant     = 4'b0010;
    out_ready = 1'b0;
    tick();
    grant = '0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("to_valid", 32'(out_valid), 32'(1));
      chk("to_pop", 32'(src_pop), 32'(0));
      chk("to_err_early", 32'(err_timeout), 32'(0));
      tick();
    end
    #1;
    chk("to_ack", 32'(ack), 32'(1));
    chk("to_valid_drop", 32'(out_valid), 32'(0));
    chk("to_err", 32'(err_timeout), 32'(1));
    tick();
    #1;
    chk("to_gap_ack", 32'(ack), 32'(0));
    tick();
    #1;
    chk("to_idle_busy", 32'(busy), 32'(0));
    chk("to_err_sticky", 32'(err_timeout), 32'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_grant_servicer.md
Name: arb_grant_servicer

Overview:
- Downstream consumer of the round-robin arbiter. It latches the one-hot grant vector and streams the granted requester's beats onto a single valid/ready output channel.
- When the last beat is accepted, it returns a one-cycle ack to the arbiter so the arbiter can rotate priority.
- It also pops the per-requester source queue once per accepted beat.

Parameters:
- WIDTH, 4, number of requesters; must match the arbiter's WIDTH.
- DATA_W, 8, beat data width.
- LEN_W, 4, width of the per-requester beat-count field.
- CHAN_W, 2, width of the channel index; must equal clog2(WIDTH).
- TIMEOUT_CYCLES, 16, stall limit used only when ARB_SVC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- resetb  in  1  asynchronous active-low reset.
- grant  in  WIDTH  one-hot grant from the arbiter.
- ack  out  1  one-cycle pulse to the arbiter when the service is complete.
- req_data  in  WIDTH*DATA_W  head-of-queue data per requester; slice i = bits [i*DATA_W +: DATA_W].
- req_len  in  WIDTH*LEN_W  beat count per requester, same slicing.
- src_pop  out  WIDTH  one-hot pop to the granted source queue, one cycle per accepted beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  output beat data.
- out_chan  out  CHAN_W  index of the channel being served.
- out_last  out  1  marks the final beat of the service.
- busy  out  1  high in any state other than IDLE.
- err_grant  out  1  sticky: a multi-hot grant was seen in IDLE.
- err_timeout  out  1  sticky timeout flag; tied 0 when ARB_SVC_TIMEOUT_EN is undefined.

Behaviour:
- Reset (resetb=0, asynchronous):
  - State = IDLE.
  - ack, src_pop, out_valid, out_last, busy, err_grant and err_timeout = 0.
  - out_chan = 0, beat counter = 0, latched length = 0.
  - out_data = 0.
  - Reset asserted mid-transfer aborts immediately: no ack, no further pops.
- State machine: IDLE -> XFER -> DONE -> GAP -> IDLE.
- IDLE:
  - grant==0: stay in IDLE.
  - grant one-hot: latch the channel index into out_chan and req_len[chan] into the length register, clear the beat counter.
    - Next state is XFER, or DONE if the latched length is 0.
  - grant multi-hot: set err_grant, stay in IDLE, no ack.
- XFER:
  - out_valid=1.
  - out_data = req_data slice of the latched channel (combinational from the latched index). The source holds the slice stable until it is popped.
  - out_last=1 when beat counter == length-1.
  - Beat accepted on out_valid&&out_ready: src_pop[out_chan]=1 in the same cycle, counter increments.
  - After the last beat is accepted: next state is DONE.
  - out_valid deasserts in the cycle after the last acceptance.
  - While out_ready=0: out_valid, out_data and out_last hold, no pop.
  - Grant changes during XFER are ignored; the service is bound to the latched channel.
- DONE: ack=1 for exactly this cycle, then GAP.
- GAP:
  - One idle cycle, ack=0, grant ignored.
  - Lets the arbiter's registered post-ack grant settle, so the stale grant is never re-serviced.
  - Then IDLE.
- Timing and throughput:
  - Grant sampled at edge N gives out_valid high from cycle N+1.
  - Minimum service of 1 beat with out_ready held 1: grant sampled -> XFER (1 cycle) -> DONE (ack) -> GAP -> IDLE.
  - The next grant is sampled 4 cycles after the previous one.
  - Zero-length service: IDLE -> DONE -> GAP, ack only, no out_valid, no pop.
- Width rules:
  - The beat counter is LEN_W wide.
  - Maximum length is 2^LEN_W-1; there is no wrap inside a service.
- err_grant and err_timeout clear only on reset.

Optional Feature:
- Macro: ARB_SVC_TIMEOUT_EN.
- Defined:
  - A stall counter increments each XFER cycle with out_valid=1 and out_ready=0, and clears on any accepted beat.
  - On reaching TIMEOUT_CYCLES: set err_timeout, drop out_valid, go to DONE and ack normally. Remaining beats are abandoned and not popped.
- Undefined: no counter; err_timeout tied 0; XFER waits indefinitely.

Test Plan:
- Reset mid-XFER: grant=4'b0100, len=3, drop resetb after 1 accepted beat -> all outputs 0 asynchronously, no ack; after release the block sits in IDLE with busy=0.
- Single requester: grant=4'b0010, len[1]=3, out_ready=1 -> out_chan=1.
  - 3 beats on consecutive cycles carry req_data[1]; src_pop=4'b0010 on each beat; out_last on beat 3.
  - ack pulses 1 cycle after the last beat.
- Backpressure: grant=4'b1000, len=2, out_ready low for 3 cycles on beat 1 -> out_valid/out_data stable, no pop during the stall; exactly 2 pops total, then 1 ack.
- Zero length and stale grant: grant=4'b0001, len[0]=0, grant held high through GAP -> exactly one ack per service, no out_valid; the next service starts only when grant is resampled in IDLE.
- Multi-hot: grant=4'b0110 in IDLE -> err_grant=1, no ack, busy=0; a later grant=4'b0100 services normally and err_grant stays 1.
- Timeout (macro defined, TIMEOUT_CYCLES=16): len=4, out_ready=0 permanently -> after 16 stall cycles err_timeout=1, out_valid=0, one ack, zero pops.
